// File: rtl/pb_debounce_pkg.sv
// Shared definitions for the push-button debounce scheduler: FSM state encoding
// and the width helper used to size the timer and the button index.
package pb_debounce_pkg;

  typedef enum logic {
    SCAN  = 1'b0,
    COUNT = 1'b1
  } state_e;

  // At least one bit so that a single-button bank still has a legal index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pb_sync2.sv
// Two-flop synchronizer for a vector of asynchronous inputs, cleared to 0 by a
// synchronous active-high reset.
module pb_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pb_debounce_scheduler.sv
// Debounces NUM_PB push-buttons with one shared timer; a round-robin scheduler
// grants the timer to one button whose synchronized level differs from its status.
module pb_debounce_scheduler
  import pb_debounce_pkg::*;
#(
  parameter int unsigned NUM_PB = 4,
  parameter int unsigned DELAY  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_PB-1:0] PB,
  output logic [NUM_PB-1:0] PB_pressed_status,
  output logic [NUM_PB-1:0] PB_pressed_pulse,
  output logic [NUM_PB-1:0] PB_released_pulse
);

  localparam int unsigned IDX_W = idx_width(NUM_PB);
  localparam int unsigned TMR_W = idx_width(DELAY);

  logic [NUM_PB-1:0] pb_sync;
  logic [NUM_PB-1:0] diff;

  state_e            state_q,  state_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [IDX_W-1:0]  ptr_q,    ptr_d;
  logic [TMR_W-1:0]  timer_q,  timer_d;
  logic [NUM_PB-1:0] status_q, status_d;
  logic [NUM_PB-1:0] press_q,  press_d;
  logic [NUM_PB-1:0] rel_q,    rel_d;

  logic              found;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  next_idx;

  pb_sync2 #(
    .WIDTH(NUM_PB)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (PB),
    .q_o (pb_sync)
  );

  assign diff = pb_sync ^ status_q;

  // Rotate by ptr, pick the lowest set bit, rotate back: folded into one loop
  // that visits candidates in circular order starting at ptr.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_PB; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_PB);
      if (diff[cand] && !found) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign next_idx = (idx_q == IDX_W'(NUM_PB - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    timer_d  = timer_q;
    status_d = status_q;
    press_d  = '0;
    rel_d    = '0;
    case (state_q)
      SCAN: begin
        if (found) begin
          idx_d   = grant;
          timer_d = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (!diff[idx_q]) begin
          ptr_d   = next_idx;
          state_d = SCAN;
        end else if (timer_q == TMR_W'(DELAY - 1)) begin
          status_d[idx_q] = ~status_q[idx_q];
          if (status_q[idx_q]) rel_d[idx_q]   = 1'b1;
          else                 press_d[idx_q] = 1'b1;
          ptr_d   = next_idx;
          state_d = SCAN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SCAN;
      idx_q    <= '0;
      ptr_q    <= '0;
      timer_q  <= '0;
      status_q <= '0;
      press_q  <= '0;
      rel_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      timer_q  <= timer_d;
      status_q <= status_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign PB_pressed_status = status_q;
  assign PB_pressed_pulse  = press_q;
  assign PB_released_pulse = rel_q;

endmodule

// File: tb/tb_pb_debounce_scheduler.sv
// Directed and random checks of pb_debounce_scheduler against a cycle-level
// reference model that tracks grants as a countdown of remaining stable cycles.
module tb_pb_debounce_scheduler;

  localparam int NUM = 4;
  localparam int DLY = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NUM-1:0] PB  = '0;
  logic [NUM-1:0] PB_pressed_status;
  logic [NUM-1:0] PB_pressed_pulse;
  logic [NUM-1:0] PB_released_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [NUM-1:0] m_s1, m_s2, m_st, m_press, m_rel;
  int             m_owner  = -1;
  int             m_remain = 0;
  int             m_start  = 0;

  pb_debounce_scheduler #(
    .NUM_PB(NUM),
    .DELAY (DLY)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .PB                (PB),
    .PB_pressed_status (PB_pressed_status),
    .PB_pressed_pulse  (PB_pressed_pulse),
    .PB_released_pulse (PB_released_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NUM-1:0] obs, input logic [NUM-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advances the model by one rising edge, given the inputs present at that edge.
  task automatic model_step(input logic r, input logic [NUM-1:0] pb);
    logic [NUM-1:0] pend;
    bit             got;
    int             j;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_st = '0; m_press = '0; m_rel = '0;
      m_owner = -1; m_remain = 0; m_start = 0;
      return;
    end
    m_press = '0;
    m_rel   = '0;
    pend    = m_s2 ^ m_st;
    if (m_owner < 0) begin
      got = 0;
      for (int k = 0; k < NUM; k++) begin
        j = (m_start + k) % NUM;
        if (!got && pend[j]) begin
          got      = 1;
          m_owner  = j;
          m_remain = DLY;
        end
      end
    end else if (!pend[m_owner]) begin
      m_start = (m_owner + 1) % NUM;
      m_owner = -1;
    end else begin
      m_remain--;
      if (m_remain == 0) begin
        if (m_st[m_owner]) m_rel[m_owner] = 1'b1;
        else               m_press[m_owner] = 1'b1;
        m_st[m_owner] = ~m_st[m_owner];
        m_start = (m_owner + 1) % NUM;
        m_owner = -1;
      end
    end
    m_s2 = m_s1;
    m_s1 = pb;
  endtask

  task automatic tick();
    logic [NUM-1:0] prev;
    logic           ok;
    prev = PB_pressed_status;
    @(posedge clk);
    model_step(rst, PB);
    #1;
    check("status", PB_pressed_status, m_st);
    check("pressed_pulse", PB_pressed_pulse, m_press);
    check("released_pulse", PB_released_pulse, m_rel);
    ok = ($countones({PB_pressed_pulse, PB_released_pulse}) <= 1);
    check("one_pulse_max", {3'b000, ok}, 4'b0001);
    ok = ((PB_pressed_pulse & ~(~prev & PB_pressed_status)) == '0) &&
         ((PB_released_pulse & ~(prev & ~PB_pressed_status)) == '0);
    check("pulse_polarity", {3'b000, ok}, 4'b0001);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // Reset with all buttons held; bits commit in index order afterwards
    rst = 1'b1;
    PB  = 4'b1111;
    ticks(3);
    check("rst_status", PB_pressed_status, 4'b0000);
    check("rst_press", PB_pressed_pulse, 4'b0000);
    check("rst_release", PB_released_pulse, 4'b0000);
    rst = 1'b0;
    ticks(12);
    check("rst_b0_before", PB_pressed_pulse, 4'b0000);
    tick();
    check("rst_b0_e12", PB_pressed_pulse, 4'b0001);
    ticks(40);
    check("rst_all_held", PB_pressed_status, 4'b1111);
    PB = 4'b0000;
    ticks(60);
    check("all_released", PB_pressed_status, 4'b0000);

    // Clean press and release of PB[2]
    PB = 4'b0100;
    ticks(12);
    check("press2_before", PB_pressed_pulse, 4'b0000);
    tick();
    check("press2_e12", PB_pressed_pulse, 4'b0100);
    check("press2_status", PB_pressed_status, 4'b0100);
    tick();
    check("press2_drop", PB_pressed_pulse, 4'b0000);
    ticks(36);
    PB = 4'b0000;
    ticks(12);
    check("rel2_before", PB_released_pulse, 4'b0000);
    tick();
    check("rel2_e12", PB_released_pulse, 4'b0100);
    check("rel2_status", PB_pressed_status, 4'b0000);
    ticks(5);

    // Bounce on PB[1]: 5 high, 3 low, then steady high
    PB = 4'b0010;
    ticks(5);
    PB = 4'b0000;
    ticks(3);
    PB = 4'b0010;
    ticks(12);
    check("bounce_no_pulse", PB_pressed_pulse, 4'b0000);
    check("bounce_status", PB_pressed_status, 4'b0000);
    tick();
    check("bounce_commit", PB_pressed_pulse, 4'b0010);
    PB = 4'b0000;
    ticks(20);

    // PB[3] event moves the pointer to 0
    PB = 4'b1000;
    ticks(15);
    PB = 4'b0000;
    ticks(15);

    // Simultaneous PB[0] and PB[3] with ptr=0
    PB = 4'b1001;
    ticks(12);
    tick();
    check("sim_p0_first", PB_pressed_pulse, 4'b0001);
    ticks(10);
    tick();
    check("sim_p3_second", PB_pressed_pulse, 4'b1000);
    check("sim_status", PB_pressed_status, 4'b1001);
    PB = 4'b0000;
    ticks(30);

    // PB[2] event moves the pointer to 3
    PB = 4'b0100;
    ticks(15);
    PB = 4'b0000;
    ticks(15);

    // Simultaneous PB[0] and PB[3] with ptr=3
    PB = 4'b1001;
    ticks(12);
    tick();
    check("ptr3_p3_first", PB_pressed_pulse, 4'b1000);
    ticks(10);
    tick();
    check("ptr3_p0_second", PB_pressed_pulse, 4'b0001);
    PB = 4'b0000;
    ticks(30);

    // Reset while PB[1] is being timed (timer=5)
    PB = 4'b0010;
    ticks(8);
    rst = 1'b1;
    ticks(2);
    check("midrst_status", PB_pressed_status, 4'b0000);
    check("midrst_press", PB_pressed_pulse, 4'b0000);
    rst = 1'b0;
    ticks(12);
    check("midrst_before", PB_pressed_pulse, 4'b0000);
    tick();
    check("midrst_e12", PB_pressed_pulse, 4'b0010);
    PB = 4'b0000;
    ticks(20);

    // Random stress: occasional toggles give both bounces and long holds
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NUM; b++) begin
        if ($urandom_range(0, 29) == 0) PB[b] = ~PB[b];
      end
      tick();
    end
    PB = 4'b0000;
    ticks(100);
    check("final_idle", PB_pressed_status, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pb_debounce_scheduler.md
# pb_debounce_scheduler

Debounce controller for a bank of mechanical push-buttons that shares one debounce timer among `NUM_PB` inputs through a round-robin scheduler. It replaces one full timer and FSM per button on the board-level input path. Each raw input is double-flop synchronized. The scheduler grants the shared timer to one button whose synchronized level differs from its committed status, then either commits the change or aborts it. Downstream logic (CPU step/run control, mode selection) consumes per-button level and pulse vectors.

## Interface
- `NUM_PB`, default 4: number of buttons (≥1).
- `DELAY`, default 10: clock cycles a changed level must remain stable before commit (≥2).
- `clk` in 1: base clock; all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `PB` in NUM_PB: raw asynchronous button inputs, active-high.
- `PB_pressed_status` out NUM_PB: committed debounced level per button (registered).
- `PB_pressed_pulse` out NUM_PB: one-cycle pulse on committed 0→1 (registered).
- `PB_released_pulse` out NUM_PB: one-cycle pulse on committed 1→0 (registered).

## Operation
- Reset: sync flops, `PB_pressed_status`, both pulse vectors, timer, and pointer `ptr` all go to 0. State goes to SCAN.
- `PB_sync[i]` is `PB[i]` delayed by two flops. `diff[i] = PB_sync[i] ^ PB_pressed_status[i]`.
- SCAN:
  - Pick the first `i` with `diff[i]=1`, searching circularly from `ptr` (`ptr`, `ptr+1`, … wrapping at NUM_PB).
  - If one is found: latch `idx=i`, clear the timer, go to COUNT.
  - Otherwise: stay in SCAN.
- COUNT:
  - If `diff[idx]=0` (bounce back): abort, set `ptr=(idx+1) mod NUM_PB`, go to SCAN. No pulse, status unchanged.
  - Else if `timer == DELAY-1`: commit. Toggle `PB_pressed_status[idx]`. Assert `PB_pressed_pulse[idx]` if the new level is 1, otherwise `PB_released_pulse[idx]`. Set `ptr=(idx+1) mod NUM_PB`, go to SCAN.
  - Else: increment the timer.
- Timer width: `$clog2(DELAY)` bits. The timer never exceeds DELAY-1, so it never wraps.
- Pulses default to 0 every cycle. At most one bit across both pulse vectors is high in any cycle.
- Simultaneous changes: the lowest circular index from `ptr` wins. The others stay pending (`diff` held) and are served in later SCAN passes. No event is lost while the level persists.
- Reset mid-COUNT: abort with no pulse. All state is cleared.
- Only the granted button is timed. Changes on other buttons during COUNT are not timed but are not lost.

## Timing
- Isolated change with the scheduler idle:
  - Edge E0 first samples the new `PB[i]`.
  - SCAN sees `diff[i]` after E1.
  - COUNT is entered at E2 with timer 0.
  - Commit edge is E(DELAY+2): status and pulse change there, and the pulse drops at E(DELAY+3).
- Every grant ends in SCAN for at least one cycle before the next grant, so the minimum spacing between commits is DELAY+1 cycles.
- Worst-case latency to commit for one button with all others contending: (NUM_PB-1)·(DELAY+1) + DELAY + 2 cycles after E0.
- A button still held after a commit has `diff=0` and is not rescheduled until its level changes.

## Structure
- Shared package `pb_debounce_pkg`:
  - state encodings SCAN=0, COUNT=1;
  - a `clog2`-based width helper for the timer and index.
- Sub-module `pb_sync2`: two-flop synchronizer, parameterized width, synchronous active-high reset to 0. Instantiated once for the whole `PB` vector.
- The round-robin search is a combinational rotate-priority-rotate inside the top module.

## Test plan
- Reset, NUM_PB=4, DELAY=10: assert `rst` 3 cycles with `PB=4'b1111`. All outputs stay 0 during reset. After release, bit 0 commits at E12 counted from the first sampling edge.
- Clean press on PB[2], others low: `PB_pressed_pulse=4'b0100` for exactly one cycle at E12 and `PB_pressed_status[2]=1` from then on. Release 50 cycles later gives `PB_released_pulse=4'b0100` at release E12.
- Bounce: PB[1] high 5 cycles, low 3 cycles, then high steady. No pulse for the glitch; a single pressed pulse follows the steady-high window.
- Simultaneous press of PB[0] and PB[3], `ptr=0`: PB[0] pulses at E12 and PB[3] pulses 11 cycles later. With `ptr=3` initially (after a prior PB[2] event), PB[3] is served first.
- Reset asserted when timer=5 during COUNT on PB[1]: no pulse, status stays 0. After reset, the held button commits at E12 from its first post-reset sampling edge.
- Random stress on all 4 buttons: a scoreboard checks status equals a reference debounce, at most one pulse per cycle, and pulse polarity matches the status transition.
